// File: rtl/iq_sched_pkg.sv
// iq_sched_pkg: shared types and default sizes for the IQ stream scheduler.
package iq_sched_pkg;
    typedef enum logic {IDLE, BURST} state_t;
    typedef enum logic {CH_A, CH_B} chan_t;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_LEN_W      = 8;
endpackage

// File: rtl/iq_stream_scheduler_if.sv
// iq_stream_scheduler_if: channel inputs, control and Avalon-ST output of the scheduler.
interface iq_stream_scheduler_if #(
    parameter int DATA_W = iq_sched_pkg::DEF_DATA_W,
    parameter int LEN_W  = iq_sched_pkg::DEF_LEN_W
);
    logic [DATA_W-1:0] iq_word_a, iq_word_b;
    logic              word_valid_a, word_valid_b;
    logic              en_a, en_b;
    logic [LEN_W-1:0]  pkt_len;
    logic              ovf_clr;
    logic [DATA_W-1:0] stream_tdata;
    logic              stream_tvalid, stream_tready;
    logic              stream_tstart, stream_tlast, stream_tchannel;
    logic              ovf_a, ovf_b;

    modport master (
        output iq_word_a, iq_word_b, word_valid_a, word_valid_b, en_a, en_b,
               pkt_len, ovf_clr, stream_tready,
        input  stream_tdata, stream_tvalid, stream_tstart, stream_tlast,
               stream_tchannel, ovf_a, ovf_b
    );
    modport slave (
        input  iq_word_a, iq_word_b, word_valid_a, word_valid_b, en_a, en_b,
               pkt_len, ovf_clr, stream_tready,
        output stream_tdata, stream_tvalid, stream_tstart, stream_tlast,
               stream_tchannel, ovf_a, ovf_b
    );
endinterface

// File: rtl/iq_chan_fifo.sv
// iq_chan_fifo: show-ahead synchronous FIFO; caller only pushes when not full (or popping) and pops when not empty.
module iq_chan_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;

    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/iq_stream_scheduler.sv
// iq_stream_scheduler: buffers two I/Q channels and emits them as whole round-robin packets on Avalon-ST.
module iq_stream_scheduler
    import iq_sched_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    iq_stream_scheduler_if.slave bus
);
    state_t            state_q;
    chan_t             chan_q, prio_q, grant;
    logic [LEN_W-1:0]  cnt_q, len_eff;
    logic              first_q;
    logic [DATA_W-1:0] tdata_q, dout_a, dout_b, sel_data;
    logic              tvalid_q, tstart_q, tlast_q, tchan_q;
    logic              ovf_a_q, ovf_b_q, ovf_a_d, ovf_b_d;
    logic              req_a, req_b, push_a, push_b, pop_a, pop_b;
    logic              full_a, full_b, empty_a, empty_b;
    logic              sel_empty, take, load;
    logic [1:0]        avail;

    assign req_a  = bus.word_valid_a && bus.en_a;
    assign req_b  = bus.word_valid_b && bus.en_b;
    assign push_a = req_a && (!full_a || pop_a);
    assign push_b = req_b && (!full_b || pop_b);
    // a same-cycle overflow beats the clear
    assign ovf_a_d = (req_a && full_a && !pop_a) || (ovf_a_q && !bus.ovf_clr);
    assign ovf_b_d = (req_b && full_b && !pop_b) || (ovf_b_q && !bus.ovf_clr);

    assign sel_empty = chan_q == CH_A ? empty_a : empty_b;
    assign sel_data  = chan_q == CH_A ? dout_a : dout_b;
    assign take      = tvalid_q && bus.stream_tready;
    assign load      = state_q == BURST && (!tvalid_q || take) && cnt_q != '0 && !sel_empty;
    assign pop_a     = load && chan_q == CH_A;
    assign pop_b     = load && chan_q == CH_B;

    assign avail   = {bus.en_b && !empty_b, bus.en_a && !empty_a};
    assign grant   = avail[prio_q] ? prio_q : chan_t'(~prio_q);
    assign len_eff = bus.pkt_len == '0 ? LEN_W'(1) : bus.pkt_len;

    iq_chan_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk(clk), .rst(reset), .push_i(push_a), .pop_i(pop_a), .din_i(bus.iq_word_a),
        .dout_o(dout_a), .full_o(full_a), .empty_o(empty_a)
    );
    iq_chan_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk(clk), .rst(reset), .push_i(push_b), .pop_i(pop_b), .din_i(bus.iq_word_b),
        .dout_o(dout_b), .full_o(full_b), .empty_o(empty_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            chan_q   <= CH_A;
            prio_q   <= CH_A;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tstart_q <= 1'b0;
            tlast_q  <= 1'b0;
            tchan_q  <= 1'b0;
            ovf_a_q  <= 1'b0;
            ovf_b_q  <= 1'b0;
        end else begin
            ovf_a_q <= ovf_a_d;
            ovf_b_q <= ovf_b_d;
            if (load) begin
                tdata_q  <= sel_data;
                tstart_q <= first_q;
                tlast_q  <= cnt_q == LEN_W'(1);
                tchan_q  <= chan_q;
                tvalid_q <= 1'b1;
                cnt_q    <= cnt_q - LEN_W'(1);
                first_q  <= 1'b0;
            end else if (take) begin
                tvalid_q <= 1'b0;
            end
            case (state_q)
                IDLE: if (|avail) begin
                    chan_q  <= grant;
                    cnt_q   <= len_eff;
                    first_q <= 1'b1;
                    state_q <= BURST;
                end
                BURST: if (take && tlast_q) begin
                    state_q <= IDLE;
                    prio_q  <= chan_t'(~chan_q);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.stream_tdata    = tdata_q;
    assign bus.stream_tvalid   = tvalid_q;
    assign bus.stream_tstart   = tstart_q;
    assign bus.stream_tlast    = tlast_q;
    assign bus.stream_tchannel = tchan_q;
    assign bus.ovf_a           = ovf_a_q;
    assign bus.ovf_b           = ovf_b_q;
endmodule

// File: tb/tb_iq_stream_scheduler.sv
// tb_iq_stream_scheduler: directed scenario tests for iq_stream_scheduler with hand-computed expectations.
module tb_iq_stream_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic ok, s, l, c;
    logic [31:0] d;

    iq_stream_scheduler_if #(.DATA_W(32), .LEN_W(8)) bus ();
    iq_stream_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.word_valid_a = 0; bus.word_valid_b = 0; bus.en_a = 0; bus.en_b = 0;
        bus.iq_word_a = 0; bus.iq_word_b = 0; bus.pkt_len = 0; bus.ovf_clr = 0;
        bus.stream_tready = 0;
        reset = 1;
        tick();
        reset = 0;
    endtask

    // waits (bounded) for a beat that will transfer on the next edge, then lets it transfer
    task automatic get_beat(output logic bok, output logic [31:0] bd, output logic bs, bl, bc);
        bok = 0; bd = 0; bs = 0; bl = 0; bc = 0;
        for (int i = 0; i < 20 && !bok; i++) begin
            if (bus.stream_tvalid && bus.stream_tready) begin
                bok = 1; bd = bus.stream_tdata; bs = bus.stream_tstart;
                bl = bus.stream_tlast; bc = bus.stream_tchannel;
            end else tick();
        end
        if (bok) tick();
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1;
        tick();
        total++;
        if ({bus.stream_tvalid, bus.stream_tstart, bus.stream_tlast, bus.stream_tchannel, bus.ovf_a, bus.ovf_b, bus.stream_tdata} !== 38'd0) begin
            bad++; $display("FAIL reset_held flags/data=%h want 0", {bus.stream_tvalid, bus.stream_tstart, bus.stream_tlast, bus.stream_tchannel, bus.ovf_a, bus.ovf_b, bus.stream_tdata});
        end
        reset = 0;
        tick();
        total++;
        if ({bus.stream_tvalid, bus.stream_tstart, bus.stream_tlast, bus.stream_tchannel, bus.ovf_a, bus.ovf_b, bus.stream_tdata} !== 38'd0) begin
            bad++; $display("FAIL reset_released got=%h want 0", {bus.stream_tvalid, bus.stream_tstart, bus.stream_tlast, bus.stream_tchannel, bus.ovf_a, bus.ovf_b, bus.stream_tdata});
        end
    endtask

    task automatic test_partial_packet();
        logic [31:0] w;
        do_reset();
        bus.pkt_len = 4; bus.en_a = 1; bus.stream_tready = 1;
        for (int i = 0; i < 3; i++) begin
            bus.iq_word_a = 32'h11111111 * (i + 1); bus.word_valid_a = 1;
            tick();
        end
        bus.word_valid_a = 0;
        for (int i = 0; i < 3; i++) begin
            w = 32'h11111111 * (i + 1);
            get_beat(ok, d, s, l, c);
            total++;
            if ({ok, d, s, l, c} !== {1'b1, w, i == 0, 1'b0, 1'b0}) begin
                bad++; $display("FAIL partial_beat%0d got ok=%b d=%h s=%b l=%b c=%b want d=%h s=%b l=0 c=0", i, ok, d, s, l, c, w, i == 0);
            end
        end
        tick(); tick(); tick();
        total++;
        if (bus.stream_tvalid !== 1'b0) begin
            bad++; $display("FAIL partial_gap tvalid=%b want 0", bus.stream_tvalid);
        end
        bus.iq_word_a = 32'h44444444; bus.word_valid_a = 1;
        tick();
        bus.word_valid_a = 0;
        get_beat(ok, d, s, l, c);
        total++;
        if ({ok, d, s, l, c} !== {1'b1, 32'h44444444, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL partial_last got ok=%b d=%h s=%b l=%b c=%b want 44444444 s=0 l=1 c=0", ok, d, s, l, c);
        end
    endtask

    task automatic test_len0_latency();
        do_reset();
        bus.pkt_len = 0; bus.en_b = 1; bus.stream_tready = 1;
        bus.iq_word_b = 32'hDEADBEEF; bus.word_valid_b = 1;
        tick();
        bus.word_valid_b = 0;
        total++;
        if (bus.stream_tvalid !== 1'b0) begin
            bad++; $display("FAIL latency_e0 tvalid=%b want 0", bus.stream_tvalid);
        end
        tick();
        total++;
        if (bus.stream_tvalid !== 1'b0) begin
            bad++; $display("FAIL latency_e1 tvalid=%b want 0", bus.stream_tvalid);
        end
        tick();
        total++;
        if ({bus.stream_tvalid, bus.stream_tdata, bus.stream_tstart, bus.stream_tlast, bus.stream_tchannel} !== {1'b1, 32'hDEADBEEF, 3'b111}) begin
            bad++; $display("FAIL len0_beat got v=%b d=%h s=%b l=%b c=%b want 1 deadbeef 1 1 1", bus.stream_tvalid, bus.stream_tdata, bus.stream_tstart, bus.stream_tlast, bus.stream_tchannel);
        end
        tick();
        total++;
        if (bus.stream_tvalid !== 1'b0) begin
            bad++; $display("FAIL len0_after tvalid=%b want 0", bus.stream_tvalid);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] w;
        logic ch;
        do_reset();
        bus.pkt_len = 2; bus.en_a = 1; bus.en_b = 1; bus.stream_tready = 0;
        for (int i = 0; i < 4; i++) begin
            bus.iq_word_a = 32'hA0000000 + i; bus.iq_word_b = 32'hB0000000 + i;
            bus.word_valid_a = 1; bus.word_valid_b = 1;
            tick();
        end
        bus.word_valid_a = 0; bus.word_valid_b = 0;
        total++;
        if ({bus.ovf_a, bus.ovf_b} !== 2'b00) begin
            bad++; $display("FAIL rr_no_ovf got=%b want 00", {bus.ovf_a, bus.ovf_b});
        end
        bus.stream_tready = 1;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 2; k++) begin
                ch = p % 2;
                w = (ch ? 32'hB0000000 : 32'hA0000000) + (p / 2) * 2 + k;
                get_beat(ok, d, s, l, c);
                total++;
                if ({ok, d, s, l, c} !== {1'b1, w, k == 0, k == 1, ch}) begin
                    bad++; $display("FAIL rr_p%0d_b%0d got ok=%b d=%h s=%b l=%b c=%b want d=%h c=%b", p, k, ok, d, s, l, c, w, ch);
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.pkt_len = 4; bus.en_a = 1; bus.stream_tready = 0;
        for (int i = 1; i <= 6; i++) begin
            bus.iq_word_a = 32'h100 + i; bus.word_valid_a = 1;
            tick();
        end
        bus.word_valid_a = 0;
        total++;
        if (bus.ovf_a !== 1'b1 || bus.ovf_b !== 1'b0) begin
            bad++; $display("FAIL ovf_set ovf_a=%b ovf_b=%b want 1 0", bus.ovf_a, bus.ovf_b);
        end
        bus.iq_word_a = 32'h107; bus.word_valid_a = 1; bus.ovf_clr = 1;
        tick();
        bus.word_valid_a = 0; bus.ovf_clr = 0;
        total++;
        if (bus.ovf_a !== 1'b1) begin
            bad++; $display("FAIL ovf_clr_vs_drop ovf_a=%b want 1", bus.ovf_a);
        end
        bus.ovf_clr = 1;
        tick();
        bus.ovf_clr = 0;
        total++;
        if (bus.ovf_a !== 1'b0) begin
            bad++; $display("FAIL ovf_clr ovf_a=%b want 0", bus.ovf_a);
        end
        total++;
        if ({bus.stream_tvalid, bus.stream_tdata, bus.stream_tstart} !== {1'b1, 32'h101, 1'b1}) begin
            bad++; $display("FAIL ovf_head got v=%b d=%h s=%b want 1 101 1", bus.stream_tvalid, bus.stream_tdata, bus.stream_tstart);
        end
        // pop of the full FIFO coincides with this push, so it must be accepted
        bus.stream_tready = 1; bus.iq_word_a = 32'h108; bus.word_valid_a = 1;
        tick();
        bus.word_valid_a = 0;
        total++;
        if (bus.ovf_a !== 1'b0) begin
            bad++; $display("FAIL ovf_push_pop ovf_a=%b want 0", bus.ovf_a);
        end
        for (int i = 2; i <= 4; i++) begin
            get_beat(ok, d, s, l, c);
            total++;
            if ({ok, d, s, l, c} !== {1'b1, 32'h100 + i, 1'b0, i == 4, 1'b0}) begin
                bad++; $display("FAIL ovf_word%0d got ok=%b d=%h s=%b l=%b want d=%h", i, ok, d, s, l, 32'h100 + i);
            end
        end
        bus.pkt_len = 2;
        get_beat(ok, d, s, l, c);
        total++;
        if ({ok, d, s, l, c} !== {1'b1, 32'h105, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL ovf_word5 got ok=%b d=%h s=%b l=%b want 105 s=1 l=0", ok, d, s, l);
        end
        get_beat(ok, d, s, l, c);
        total++;
        if ({ok, d, s, l, c} !== {1'b1, 32'h108, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL ovf_word8 got ok=%b d=%h s=%b l=%b want 108 s=0 l=1", ok, d, s, l);
        end
        tick(); tick(); tick();
        total++;
        if (bus.stream_tvalid !== 1'b0) begin
            bad++; $display("FAIL ovf_drained tvalid=%b want 0", bus.stream_tvalid);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic held_v;
        logic [34:0] held, cur;
        do_reset();
        bus.pkt_len = 4; bus.en_a = 1; bus.stream_tready = 0;
        for (int i = 0; i < 4; i++) begin
            bus.iq_word_a = 32'hC0 + i; bus.word_valid_a = 1;
            tick();
        end
        bus.word_valid_a = 0;
        n = 0; held_v = 0; held = '0;
        for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
            bus.stream_tready = (cyc % 2) == 1;
            cur = {bus.stream_tdata, bus.stream_tstart, bus.stream_tlast, bus.stream_tchannel};
            if (held_v) begin
                total++;
                if (!bus.stream_tvalid || cur !== held) begin
                    bad++; $display("FAIL stall_stable cyc=%0d v=%b got=%h want=%h", cyc, bus.stream_tvalid, cur, held);
                end
            end
            if (bus.stream_tvalid && bus.stream_tready) begin
                total++;
                if (cur !== {32'hC0 + n, n == 0, n == 3, 1'b0}) begin
                    bad++; $display("FAIL stall_beat%0d got=%h want=%h", n, cur, {32'hC0 + n, n == 0, n == 3, 1'b0});
                end
                n++;
            end
            held_v = bus.stream_tvalid && !bus.stream_tready;
            held = cur;
            tick();
        end
        total++;
        if (n != 4 || bus.stream_tvalid !== 1'b0) begin
            bad++; $display("FAIL stall_count beats=%0d tvalid=%b want 4 0", n, bus.stream_tvalid);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.pkt_len = 4; bus.en_a = 1; bus.stream_tready = 0;
        for (int i = 0; i < 4; i++) begin
            bus.iq_word_a = 32'hE0 + i; bus.word_valid_a = 1;
            tick();
        end
        bus.word_valid_a = 0;
        bus.stream_tready = 1;
        for (int i = 0; i < 2; i++) begin
            get_beat(ok, d, s, l, c);
            total++;
            if ({ok, d, s, l} !== {1'b1, 32'hE0 + i, i == 0, 1'b0}) begin
                bad++; $display("FAIL rst_pre_beat%0d got ok=%b d=%h s=%b l=%b", i, ok, d, s, l);
            end
        end
        reset = 1;
        #1;
        total++;
        if ({bus.stream_tvalid, bus.stream_tstart, bus.stream_tlast, bus.stream_tchannel, bus.ovf_a, bus.ovf_b, bus.stream_tdata} !== 38'd0) begin
            bad++; $display("FAIL rst_mid_outputs got=%h want 0", {bus.stream_tvalid, bus.stream_tstart, bus.stream_tlast, bus.stream_tchannel, bus.ovf_a, bus.ovf_b, bus.stream_tdata});
        end
        tick();
        reset = 0;
        tick(); tick(); tick();
        total++;
        if (bus.stream_tvalid !== 1'b0 || bus.stream_tlast !== 1'b0) begin
            bad++; $display("FAIL rst_discard tvalid=%b tlast=%b want 0 0", bus.stream_tvalid, bus.stream_tlast);
        end
        bus.en_b = 1; bus.pkt_len = 1;
        bus.iq_word_a = 32'hF1; bus.iq_word_b = 32'hF2;
        bus.word_valid_a = 1; bus.word_valid_b = 1;
        tick();
        bus.word_valid_a = 0; bus.word_valid_b = 0;
        get_beat(ok, d, s, l, c);
        total++;
        if ({ok, d, s, l, c} !== {1'b1, 32'hF1, 3'b110}) begin
            bad++; $display("FAIL rst_next_a got ok=%b d=%h s=%b l=%b c=%b want f1 1 1 0", ok, d, s, l, c);
        end
        get_beat(ok, d, s, l, c);
        total++;
        if ({ok, d, s, l, c} !== {1'b1, 32'hF2, 3'b111}) begin
            bad++; $display("FAIL rst_next_b got ok=%b d=%h s=%b l=%b c=%b want f2 1 1 1", ok, d, s, l, c);
        end
        tick(); tick(); tick();
        total++;
        if (bus.stream_tvalid !== 1'b0) begin
            bad++; $display("FAIL rst_no_leftover tvalid=%b want 0", bus.stream_tvalid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_partial_packet();
        test_len0_latency();
        test_round_robin();
        test_overflow();
        test_backpressure();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iq_stream_scheduler.md
IQ_STREAM_SCHEDULER -- requirements
Module: iq_stream_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one I/Q word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, words buffered per channel (power of two, at least 2).
REQ-003 SHALL have parameter LEN_W, default 8, width of pkt_len.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports iq_word_a / iq_word_b  in  DATA_W  I/Q word from channel A (RF09) / B (RF24).
REQ-007 SHALL have ports word_valid_a / word_valid_b  in  1  one-cycle pulse, word valid.
REQ-008 SHALL have ports en_a / en_b  in  1  channel enable.
REQ-009 SHALL have port pkt_len  in  LEN_W  words per packet; 0 is treated as 1.
REQ-010 SHALL have port ovf_clr  in  1  clears both overflow flags.
REQ-011 SHALL have port stream_tdata  out  DATA_W  Avalon-ST data.
REQ-012 SHALL have ports stream_tvalid out 1 and stream_tready in 1, Avalon-ST handshake with ready latency 0.
REQ-013 SHALL have ports stream_tstart / stream_tlast  out  1  SOP / EOP.
REQ-014 SHALL have port stream_tchannel  out  1  0 = A, 1 = B.
REQ-015 SHALL have ports ovf_a / ovf_b  out  1  sticky drop flags.

Function
REQ-016 SHALL push iq_word_x into FIFO x when word_valid_x=1, en_x=1 and FIFO x is not full.
REQ-017 SHALL drop the word and set ovf_x when it is pushed into a full FIFO with no pop in the same cycle; a push and a pop in the same cycle on a full FIFO SHALL NOT overflow.
REQ-018 SHALL clear ovf_a and ovf_b on ovf_clr; an overflow in the same cycle wins, so the flag stays set.
REQ-019 SHALL use FSM states IDLE and BURST.
REQ-020 In IDLE, the FSM SHALL grant the priority channel if it is enabled and its FIFO is non-empty, otherwise the other channel under the same conditions, otherwise stay in IDLE.
REQ-021 On grant, the FSM SHALL latch the channel and max(pkt_len,1) into a beat counter and go to BURST; pkt_len changes mid-packet SHALL have no effect.
REQ-022 In BURST, the block SHALL pop the granted FIFO into the output register whenever the register is empty or being consumed (tvalid&&tready) and the FIFO is non-empty.
REQ-023 A beat SHALL transfer only when tvalid&&tready; tdata, tstart, tlast and tchannel SHALL stay stable while tvalid=1 and tready=0.
REQ-024 tstart SHALL be 1 on the first beat of a packet and tlast on the beat where the counter reaches its last count; with length 1, both SHALL be 1 on that beat.
REQ-025 If the granted FIFO empties mid-packet, tvalid SHALL go 0 and the FSM SHALL stay in BURST until the packet is complete; packets SHALL never be truncated or interleaved.
REQ-026 Deasserting en_x mid-packet SHALL stop new pushes but SHALL NOT abort the packet already in progress.
REQ-027 After the tlast beat transfers, the FSM SHALL return to IDLE and give priority to the other channel (round-robin).
REQ-028 Latency: with an idle output, tvalid SHALL assert on the 2nd rising edge after the edge that samples word_valid_x.
REQ-029 Throughput SHALL be one beat per clock while the FIFO is non-empty and tready=1; back-to-back packets MAY have one IDLE bubble.
REQ-030 stream_tdata SHALL equal iq_word_x unmodified (no byte reordering).

Reset
REQ-031 On reset, tvalid, tstart, tlast, tchannel, ovf_a, ovf_b and tdata SHALL be 0, FIFOs SHALL be empty, the state SHALL be IDLE and priority SHALL be channel A.
REQ-032 Reset asserted mid-packet SHALL discard all buffered words and the partial packet; no tlast SHALL be emitted for it.

Structure
REQ-033 Package iq_sched_pkg SHALL hold the state enum (IDLE, BURST), the channel enum (CH_A, CH_B) and default DATA_W, FIFO_DEPTH and LEN_W.
REQ-034 A sub-module iq_chan_fifo (synchronous FIFO with push, pop, full, empty and async reset) SHALL be instantiated once per channel.

Verification
REQ-035 pkt_len=4, three A words 0x11111111..0x33333333, tready=1 -> 3 beats, tstart on the first, tvalid drops, then a 4th word -> beat with tlast; tchannel=0.
REQ-036 Both FIFOs full, pkt_len=2, tready=1 -> packet order A,B,A,B, each 2 beats, tchannel toggles per packet.
REQ-037 FIFO_DEPTH=4, tready=0, 6 pulses on A -> 4 words held, ovf_a=1; ovf_clr pulse -> ovf_a=0; tready=1 -> 4 words out in order.
REQ-038 tready toggling 1/0 each cycle during a 4-beat packet -> tdata, tstart and tlast stable while stalled, no lost or duplicated beats.
REQ-039 pkt_len=0, single word 0xDEADBEEF on B -> one beat with tstart=tlast=1 and tchannel=1.
REQ-040 Reset pulse after the 2nd of 4 beats -> all outputs 0 next cycle; after new words, the next packet starts with tstart=1 on channel A priority.
